branch_predict_unit: RTL and testbench

Execute-stage branch resolution unit with a parametrised dynamic predictor; the next generation of the single-cycle branch flush logic. Each fetched PC gets a taken/not-taken prediction from a table of 2-bit saturating counters. Each resolved branch or jump in execute is checked against the prediction carried down the pipe. On a mismatch the unit drives a registered PC-select and holds flush for a configurable number of cycles.

---
 rtl/branch_pkg.sv | 30 +++
 rtl/branch_history_table.sv | 32 +++
 rtl/branch_predict_unit.sv | 89 ++++++++
 tb/tb_branch_predict_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolution unit and its history table.
// Counter states, pc_sel codes and the saturating update rule.
package branch_pkg;

  localparam logic [1:0] PCSEL_SEQ  = 2'b00;
  localparam logic [1:0] PCSEL_TGT  = 2'b01;
  localparam logic [1:0] PCSEL_FALL = 2'b10;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] BHT_RST = WNT;

  function automatic logic [1:0] ctr_next(
    input logic [1:0] c,
    input logic       t
  );
    logic [1:0] n;
    n = c;
    unique case (1'b1)
      (t && c != ST):   n = c + 2'd1;
      (!t && c != SNT): n = c - 2'd1;
      default:          n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// Array of 2-bit saturating counters with async read,
// synchronous update and asynchronous reset to weakly not-taken.
module branch_history_table #(
  parameter int ENTRIES = 16,
  parameter int IDX     = $clog2(ENTRIES)
) (
  input  logic           clk,
  input  logic           a_reset_n,
  input  logic [IDX-1:0] i_rd_idx,
  output logic           o_rd_taken,
  input  logic           i_we,
  input  logic [IDX-1:0] i_wr_idx,
  input  logic           i_taken
);
  import branch_pkg::*;

  logic [1:0] r_bht [ENTRIES];

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_bht[i] <= BHT_RST;
      end
    end else if (i_we) begin
      r_bht[i_wr_idx] <= ctr_next(r_bht[i_wr_idx], i_taken);
    end
  end

  // Read sees the pre-update value when the write targets the same entry
  assign o_rd_taken = r_bht[i_rd_idx][1];

endmodule

// File: rtl/branch_predict_unit.sv
// Execute-stage branch resolution with a 2-bit dynamic predictor,
// registered redirect select and a stretched flush.
module branch_predict_unit #(
  parameter int W            = 32,
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int MODE         = 1
) (
  input  logic         clk,
  input  logic         a_reset_n,
  input  logic [W-1:0] fe_pc,
  output logic         pred_taken,
  input  logic         ex_valid,
  input  logic [W-1:0] ex_pc,
  input  logic         ex_is_br,
  input  logic         ex_is_jmp,
  input  logic         ex_taken,
  input  logic         ex_pred_taken,
  output logic [1:0]   pc_sel,
  output logic         flush,
  output logic [31:0]  mispredict_cnt
);
  import branch_pkg::*;

  localparam int IDX = $clog2(BHT_ENTRIES);
  localparam int FCW =
    (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  logic           w_mispredict;
  logic [1:0]     w_kind;
  logic           w_bht_we;
  logic           w_bht_taken;
  logic           w_unused;
  logic [FCW-1:0] r_fc;
  logic [1:0]     r_pc_sel;
  logic [31:0]    r_cnt;

  assign w_unused = ^{fe_pc[W-1:IDX+2], fe_pc[1:0],
                      ex_pc[W-1:IDX+2], ex_pc[1:0]};

  assign w_bht_we = (MODE == 1) & ex_valid & ex_is_br;

  branch_history_table #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk        (clk),
    .a_reset_n  (a_reset_n),
    .i_rd_idx   (fe_pc[IDX+1:2]),
    .o_rd_taken (w_bht_taken),
    .i_we       (w_bht_we),
    .i_wr_idx   (ex_pc[IDX+1:2]),
    .i_taken    (ex_taken)
  );

  assign pred_taken = (MODE == 1) ? w_bht_taken : 1'b0;

  // A jump wins over a branch when both flags are set
  assign w_mispredict = ex_valid &
    (ex_is_jmp | (ex_is_br & (ex_taken != ex_pred_taken)));

  always_comb begin
    w_kind = PCSEL_SEQ;
    unique case (1'b1)
      (ex_is_jmp | ex_taken): w_kind = PCSEL_TGT;
      default:                w_kind = PCSEL_FALL;
    endcase
  end

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      r_fc     <= '0;
      r_pc_sel <= PCSEL_SEQ;
      r_cnt    <= '0;
    end else begin
      r_pc_sel <= w_mispredict ? w_kind : PCSEL_SEQ;
      if (w_mispredict) begin
        r_fc  <= FCW'(FLUSH_CYCLES);
        r_cnt <= r_cnt + 32'd1;
      end else if (r_fc != '0) begin
        r_fc <= r_fc - FCW'(1);
      end
    end
  end

  assign flush          = w_mispredict | (r_fc != '0);
  assign pc_sel         = r_pc_sel;
  assign mispredict_cnt = r_cnt;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench: dynamic unit (FLUSH_CYCLES=2) and static unit
// (MODE 0, FLUSH_CYCLES=0) driven in parallel against a counter model.
module tb_branch_predict_unit;

  logic        clk;
  logic        a_reset_n;
  logic [31:0] fe_pc;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_br;
  logic        ex_is_jmp;
  logic        ex_taken;
  logic        ex_pred_taken;

  logic        p1, f1, p0, f0;
  logic [1:0]  s1, s0;
  logic [31:0] c1, c0;

  branch_predict_unit #(
    .W(32), .BHT_ENTRIES(16), .FLUSH_CYCLES(2), .MODE(1)
  ) u_dyn (
    .clk(clk), .a_reset_n(a_reset_n), .fe_pc(fe_pc),
    .pred_taken(p1), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_is_br(ex_is_br), .ex_is_jmp(ex_is_jmp),
    .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken),
    .pc_sel(s1), .flush(f1), .mispredict_cnt(c1)
  );

  branch_predict_unit #(
    .W(32), .BHT_ENTRIES(16), .FLUSH_CYCLES(0), .MODE(0)
  ) u_sta (
    .clk(clk), .a_reset_n(a_reset_n), .fe_pc(fe_pc),
    .pred_taken(p0), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_is_br(ex_is_br), .ex_is_jmp(ex_is_jmp),
    .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken),
    .pc_sel(s0), .flush(f0), .mispredict_cnt(c0)
  );

  typedef struct {
    logic        p1;
    logic        f1;
    logic [1:0]  s1;
    logic [31:0] c1;
    logic        f0;
    logic [1:0]  s0;
    logic [31:0] c0;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference state: counters as plain ints, flush as cycles remaining
  int          m_bht [16];
  int          m_left;
  logic [1:0]  m_sel, m_sel0;
  logic [31:0] m_cnt;

  initial clk = 0;
  always #25 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic int idx(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
    m_left = 0;
    m_sel  = 2'b00;
    m_sel0 = 2'b00;
    m_cnt  = 0;
  endtask

  task automatic step(input logic v, input logic [31:0] pc,
                      input logic br, input logic jmp,
                      input logic tk, input logic pt,
                      input logic [31:0] fe);
    exp_t e;
    logic mis;
    @(posedge clk);
    #1;
    ex_valid = v; ex_pc = pc; ex_is_br = br; ex_is_jmp = jmp;
    ex_taken = tk; ex_pred_taken = pt; fe_pc = fe;
    mis  = v && (jmp || (br && tk != pt));
    e.p1 = m_bht[idx(fe)] >= 2;
    e.f1 = mis || m_left > 0;
    e.s1 = m_sel;
    e.c1 = m_cnt;
    e.f0 = mis;
    e.s0 = m_sel0;
    e.c0 = m_cnt;
    q.push_back(e);
    if (mis) begin
      m_left = 2;
      m_sel  = (jmp || tk) ? 2'b01 : 2'b10;
      m_sel0 = m_sel;
      m_cnt  = m_cnt + 1;
    end else begin
      if (m_left > 0) m_left--;
      m_sel  = 2'b00;
      m_sel0 = 2'b00;
    end
    if (v && br) begin
      if (tk) m_bht[idx(pc)] = (m_bht[idx(pc)] == 3) ? 3
                                 : m_bht[idx(pc)] + 1;
      else    m_bht[idx(pc)] = (m_bht[idx(pc)] == 0) ? 0
                                 : m_bht[idx(pc)] - 1;
    end
  endtask

  task automatic idle(input logic [31:0] fe);
    step(0, 32'h0, 0, 0, 0, 0, fe);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("dyn_pred",  32'(p1), 32'(e.p1));
      chk("dyn_flush", 32'(f1), 32'(e.f1));
      chk("dyn_pcsel", 32'(s1), 32'(e.s1));
      chk("dyn_cnt",   c1,      e.c1);
      chk("sta_pred",  32'(p0), 32'd0);
      chk("sta_flush", 32'(f0), 32'(e.f0));
      chk("sta_pcsel", 32'(s0), 32'(e.s0));
      chk("sta_cnt",   c0,      e.c0);
    end
  end

  task automatic rand_cycle();
    logic [31:0] pc, fe;
    logic v, br, jmp, tk, pt;
    pc  = {26'($urandom), 4'($urandom), 2'b00};
    fe  = {26'($urandom), 4'($urandom), 2'b00};
    v   = ($urandom % 4) != 0;
    br  = ($urandom % 3) != 0;
    jmp = ($urandom % 6) == 0;
    tk  = $urandom % 2;
    pt  = ($urandom % 2) ? (m_bht[idx(pc)] >= 2) : 1'($urandom);
    step(v, pc, br, jmp, tk, pt, fe);
  endtask

  initial begin
    a_reset_n = 0;
    fe_pc = 32'h40; ex_valid = 0; ex_pc = 0; ex_is_br = 0;
    ex_is_jmp = 0; ex_taken = 0; ex_pred_taken = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 a_reset_n = 1;
    #1;
    chk("rst_pred",  32'(p1), 32'd0);
    chk("rst_pcsel", 32'(s1), 32'd0);
    chk("rst_flush", 32'(f1), 32'd0);
    chk("rst_cnt",   c1,      32'd0);

    step(1, 32'h40, 1, 0, 1, 0, 32'h40);
    step(1, 32'h40, 1, 0, 1, 0, 32'h40);
    idle(32'h40);
    idle(32'h40);
    idle(32'h40);
    step(1, 32'h40, 1, 0, 0, 1, 32'h40);
    idle(32'h40);
    idle(32'h40);
    idle(32'h40);
    step(1, 32'h80, 0, 1, 0, 0, 32'h80);
    idle(32'h80);
    idle(32'h80);
    idle(32'h80);
    step(0, 32'h80, 0, 1, 0, 0, 32'h80);
    idle(32'h80);
    step(1, 32'h44, 1, 1, 1, 1, 32'h44);
    step(1, 32'h48, 1, 0, 0, 1, 32'h44);
    idle(32'h44);
    idle(32'h44);
    idle(32'h44);

    for (int i = 0; i < 400; i++) rand_cycle();

    step(1, 32'h4c, 1, 0, 1, 0, 32'h4c);
    @(posedge clk);
    #1;
    ex_valid = 0;
    a_reset_n = 0;
    #1;
    chk("amid_flush", 32'(f1), 32'd0);
    chk("amid_pcsel", 32'(s1), 32'd0);
    chk("amid_cnt",   c1,      32'd0);
    chk("amid_flush0", 32'(f0), 32'd0);
    for (int i = 0; i < 16; i++) begin
      fe_pc = 32'(i) << 2;
      #1;
      chk("amid_pred", 32'(p1), 32'd0);
    end
    model_reset();
    a_reset_n = 1;

    for (int i = 0; i < 150; i++) rand_cycle();

    repeat (3) @(negedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
